matrix_window_ctrl: RTL and testbench

//   Sequencer for the 3x3 window generator: tracks row/col position from the video syncs.

---
 rtl/matrix_win_pkg.sv | 12 +
 rtl/sync_edge_det.sv | 24 ++
 rtl/matrix_window_ctrl.sv | 136 +++++++++++++
 tb/tb_matrix_window_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/matrix_win_pkg.sv
// matrix_win_pkg: shared types and constants for the 3x3 window sequencer
package matrix_win_pkg;
    typedef enum logic [1:0] {IDLE, LINE_GAP, ACTIVE, FLUSH} state_e;
    localparam int IMG_W_MAX_DEF = 2048;
    localparam int ADDR_W_DEF    = 11;
    localparam int ROW_W_DEF     = 11;
    localparam logic [1:0] SEL_FIRST = 2'd0;
    localparam logic [1:0] SEL_LAST  = 2'd2;
    function automatic logic [1:0] sel_next(input logic [1:0] s);
        return (s == SEL_LAST) ? SEL_FIRST : s + 2'd1;
    endfunction
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: registered rise/fall detector with one cycle of latency
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);
    logic sig_q, rise_q, fall_q;
    // remember the previous level and flag each transition one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sig_q  <= sig_i;
            rise_q <= sig_i & ~sig_q;
            fall_q <= ~sig_i & sig_q;
        end
    end
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/matrix_window_ctrl.sv
// matrix_window_ctrl: row/col sequencer for the 3x3 window generator; LINE_FLUSH_EN adds a flush pass that emits the last window row
module matrix_window_ctrl
    import matrix_win_pkg::*;
#(
    parameter int IMG_W_MAX = IMG_W_MAX_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int ROW_W     = ROW_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    output logic              lb_wr_en,
    output logic [ADDR_W-1:0] lb_wr_addr,
    output logic [ADDR_W-1:0] lb_rd_addr,
    output logic [1:0]        lb_sel,
    output logic              win_valid,
    output logic              border_l,
    output logic              border_r,
    output logic              border_t,
    output logic              border_b,
    output logic [ADDR_W:0]   frame_width,
    output logic [ROW_W-1:0]  frame_height,
    output logic              geom_err
);
    localparam logic [ADDR_W:0]  COL_MAX = (ADDR_W + 1)'(IMG_W_MAX);
    localparam logic [ADDR_W:0]  COL_TWO = (ADDR_W + 1)'(2);
    localparam logic [ROW_W-1:0] ROW_TWO = ROW_W'(2);
    localparam logic [ROW_W-1:0] ROW_SAT = '1;

    state_e state_q, state_d;
    logic [ADDR_W:0] col_q, col_d, fw_q, fw_d;
    logic [ROW_W-1:0] row_q, row_d, fh_q, fh_d;
    logic [1:0] sel_q, sel_d;
    logic err_q, err_d, valid_q, valid_d;
    logic bl_q, bl_d, br_q, br_d, bt_q, bt_d, bb_q, bb_d;
    logic vs_rise, vs_fall, hr_fall, href_rise_unused;
    logic in_line, pix, ovf, line_end, flush, flush_start, flush_end;

    sync_edge_det u_vs (.clk(clk), .rst(rst), .sig_i(per_frame_vsync), .rise_o(vs_rise), .fall_o(vs_fall));
    sync_edge_det u_hr (.clk(clk), .rst(rst), .sig_i(per_frame_href), .rise_o(href_rise_unused), .fall_o(hr_fall));

`ifndef LINE_FLUSH_EN
    logic unused_vs_fall;
    assign unused_vs_fall = vs_fall;
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state: frame start overrides everything, then flush bounds, then line boundaries
    always_comb begin
        state_d = vs_rise ? LINE_GAP :
                  flush_end ? IDLE :
                  flush_start ? FLUSH :
                  line_end ? LINE_GAP :
                  (state_q == LINE_GAP && per_frame_href) ? ACTIVE : state_q;
    end

    // state decoded strobes; the first pixel of a line lands while still in LINE_GAP
    always_comb begin
        in_line  = (state_q == LINE_GAP) || (state_q == ACTIVE);
        pix      = in_line & per_frame_href;
        ovf      = pix & (col_q == COL_MAX);
        lb_wr_en = pix & ~ovf;
        line_end = (state_q == ACTIVE) & hr_fall;
`ifdef LINE_FLUSH_EN
        flush       = state_q == FLUSH;
        flush_start = (state_q == LINE_GAP) & vs_fall & (row_q >= ROW_TWO) & (fw_q != '0);
        flush_end   = flush & (col_q == fw_q - 1'b1);
`else
        flush       = 1'b0;
        flush_start = 1'b0;
        flush_end   = 1'b0;
`endif
    end

    // counters, ring select, geometry and window flags
    always_comb begin
        col_d   = (vs_rise | line_end | flush_end) ? '0 : ((pix & ~ovf) | flush) ? col_q + 1'b1 : col_q;
        row_d   = vs_rise ? '0 : (line_end && row_q != ROW_SAT) ? row_q + 1'b1 : row_q;
        sel_d   = vs_rise ? SEL_FIRST : line_end ? sel_next(sel_q) : sel_q;
        fw_d    = (~vs_rise & line_end & (row_q == '0)) ? col_q : fw_q;
        fh_d    = vs_rise ? row_q : fh_q;
        err_d   = vs_rise ? 1'b0 : err_q | ovf | (line_end & (row_q != '0) & (col_q != fw_q));
        valid_d = ~vs_rise & (col_q >= COL_TWO) & ((pix & (row_q >= ROW_TWO)) | flush);
        bt_d    = valid_d & (row_q == ROW_TWO);
        bl_d    = valid_d & (col_q == COL_TWO);
        br_d    = valid_d & (row_q != '0) & (col_q == fw_q - 1'b1);
        bb_d    = valid_d & flush;
    end

    // datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            sel_q   <= SEL_FIRST;
            fw_q    <= '0;
            fh_q    <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            bt_q    <= 1'b0;
            bl_q    <= 1'b0;
            br_q    <= 1'b0;
            bb_q    <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            sel_q   <= sel_d;
            fw_q    <= fw_d;
            fh_q    <= fh_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            bt_q    <= bt_d;
            bl_q    <= bl_d;
            br_q    <= br_d;
            bb_q    <= bb_d;
        end
    end

    assign lb_wr_addr   = col_q[ADDR_W-1:0];
    assign lb_rd_addr   = col_q[ADDR_W-1:0];
    assign lb_sel       = sel_q;
    assign win_valid    = valid_q;
    assign border_t     = bt_q;
    assign border_l     = bl_q;
    assign border_r     = br_q;
    assign border_b     = bb_q;
    assign frame_width  = fw_q;
    assign frame_height = fh_q;
    assign geom_err     = err_q;
endmodule

// File: tb/tb_matrix_window_ctrl.sv
// tb_matrix_window_ctrl: directed scenarios for the window sequencer (IMG_W_MAX=16 so overflow is reachable)
module tb_matrix_window_ctrl;
    localparam int AW = 4;
    localparam int RW = 11;

    logic clk = 1'b0, rst = 1'b1, vsync = 1'b0, href = 1'b0;
    logic lb_wr_en, win_valid, border_l, border_r, border_t, border_b, geom_err;
    logic [AW-1:0] lb_wr_addr, lb_rd_addr;
    logic [1:0] lb_sel;
    logic [AW:0] frame_width;
    logic [RW-1:0] frame_height;

    int total = 0, bad = 0;
    int cnt_valid = 0, cnt_bt = 0, cnt_bl = 0, cnt_br = 0, cnt_bb = 0, cnt_en = 0;
    int b_valid, b_bt, b_bl, b_br, b_bb, b_en;
    logic [AW-1:0] addr_log [32];
    logic [AW-1:0] rd_log [32];
    logic en_log [32];
    logic [1:0] sel_log;
    logic [1:0] sels [4];

    matrix_window_ctrl #(.IMG_W_MAX(16), .ADDR_W(AW), .ROW_W(RW)) dut (
        .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
        .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr), .lb_rd_addr(lb_rd_addr), .lb_sel(lb_sel),
        .win_valid(win_valid), .border_l(border_l), .border_r(border_r), .border_t(border_t),
        .border_b(border_b), .frame_width(frame_width), .frame_height(frame_height), .geom_err(geom_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (win_valid) cnt_valid <= cnt_valid + 1;
        if (border_t) cnt_bt <= cnt_bt + 1;
        if (border_l) cnt_bl <= cnt_bl + 1;
        if (border_r) cnt_br <= cnt_br + 1;
        if (border_b) cnt_bb <= cnt_bb + 1;
        if (lb_wr_en) cnt_en <= cnt_en + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_valid = cnt_valid; b_bt = cnt_bt; b_bl = cnt_bl; b_br = cnt_br; b_bb = cnt_bb; b_en = cnt_en;
    endtask

    task automatic drive_line(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            href = 1'b1;
            @(negedge clk);
            addr_log[i] = lb_wr_addr;
            rd_log[i] = lb_rd_addr;
            en_log[i] = lb_wr_en;
            if (i == 0) sel_log = lb_sel;
            step();
        end
        href = 1'b0;
        repeat (gap) step();
    endtask

    task automatic frame_start();
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        repeat (2) step();
        total++; if (lb_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got %b want 0", lb_wr_en); end
        total++; if (lb_wr_addr !== 4'd0 || lb_rd_addr !== 4'd0) begin bad++; $display("FAIL reset_addr got %0d/%0d want 0/0", lb_wr_addr, lb_rd_addr); end
        total++; if (lb_sel !== 2'd0) begin bad++; $display("FAIL reset_sel got %0d want 0", lb_sel); end
        total++; if ({win_valid, border_l, border_r, border_t, border_b} !== 5'b0) begin bad++; $display("FAIL reset_flags got %b want 00000", {win_valid, border_l, border_r, border_t, border_b}); end
        total++; if (frame_width !== 5'd0 || frame_height !== 11'd0) begin bad++; $display("FAIL reset_geom got %0d/%0d want 0/0", frame_width, frame_height); end
        total++; if (geom_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", geom_err); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_frame();
        int addr_bad;
        frame_start();
        snap();
        for (int l = 0; l < 4; l++) begin
            drive_line(8, 2);
            sels[l] = sel_log;
            addr_bad = 0;
            for (int i = 0; i < 8; i++) if (addr_log[i] !== 4'(i) || en_log[i] !== 1'b1) addr_bad++;
            total++; if (addr_bad != 0) begin bad++; $display("FAIL frame_addr line %0d got %0d bad pixels want 0", l, addr_bad); end
        end
        total++; if (sels[0] !== 2'd0 || sels[1] !== 2'd1 || sels[2] !== 2'd2 || sels[3] !== 2'd0) begin bad++; $display("FAIL frame_sel got %0d,%0d,%0d,%0d want 0,1,2,0", sels[0], sels[1], sels[2], sels[3]); end
        total++; if (cnt_valid - b_valid != 12) begin bad++; $display("FAIL frame_valid got %0d want 12", cnt_valid - b_valid); end
        total++; if (cnt_bt - b_bt != 6) begin bad++; $display("FAIL frame_border_t got %0d want 6", cnt_bt - b_bt); end
        total++; if (cnt_bl - b_bl != 2) begin bad++; $display("FAIL frame_border_l got %0d want 2", cnt_bl - b_bl); end
        total++; if (cnt_br - b_br != 2) begin bad++; $display("FAIL frame_border_r got %0d want 2", cnt_br - b_br); end
        total++; if (cnt_bb - b_bb != 0) begin bad++; $display("FAIL frame_border_b got %0d want 0", cnt_bb - b_bb); end
        total++; if (frame_width !== 5'd8) begin bad++; $display("FAIL frame_width got %0d want 8", frame_width); end
        total++; if (geom_err !== 1'b0) begin bad++; $display("FAIL frame_err got %b want 0", geom_err); end
    endtask

    task automatic test_flush();
        int exp_v;
        snap();
        vsync = 1'b0;
        repeat (15) step();
`ifdef LINE_FLUSH_EN
        exp_v = 6;
`else
        exp_v = 0;
`endif
        total++; if (cnt_valid - b_valid != exp_v) begin bad++; $display("FAIL flush_valid got %0d want %0d", cnt_valid - b_valid, exp_v); end
        total++; if (cnt_bb - b_bb != exp_v) begin bad++; $display("FAIL flush_border_b got %0d want %0d", cnt_bb - b_bb, exp_v); end
        total++; if (cnt_en - b_en != 0) begin bad++; $display("FAIL flush_wr_en got %0d want 0", cnt_en - b_en); end
        total++; if (cnt_bl - b_bl != (exp_v != 0 ? 1 : 0)) begin bad++; $display("FAIL flush_border_l got %0d want %0d", cnt_bl - b_bl, exp_v != 0 ? 1 : 0); end
    endtask

    task automatic test_geom_err();
        frame_start();
        total++; if (frame_height !== 11'd4) begin bad++; $display("FAIL geom_height got %0d want 4", frame_height); end
        drive_line(8, 2);
        drive_line(8, 2);
        total++; if (geom_err !== 1'b0) begin bad++; $display("FAIL geom_err_early got %b want 0", geom_err); end
        drive_line(7, 2);
        total++; if (geom_err !== 1'b1) begin bad++; $display("FAIL geom_err_short got %b want 1", geom_err); end
        total++; if (frame_width !== 5'd8) begin bad++; $display("FAIL geom_width got %0d want 8", frame_width); end
    endtask

    task automatic test_abort();
        frame_start();
        total++; if (geom_err !== 1'b0) begin bad++; $display("FAIL abort_err_clear got %b want 0", geom_err); end
        total++; if (frame_height !== 11'd3) begin bad++; $display("FAIL abort_prev_height got %0d want 3", frame_height); end
        drive_line(8, 2);
        vsync = 1'b0;
        repeat (2) step();
        for (int i = 0; i < 3; i++) begin href = 1'b1; step(); end
        href = 1'b0;
        vsync = 1'b1;
        repeat (2) step();
        total++; if (lb_wr_addr !== 4'd0 || lb_sel !== 2'd0) begin bad++; $display("FAIL abort_counters got addr %0d sel %0d want 0 0", lb_wr_addr, lb_sel); end
        total++; if (frame_height !== 11'd1) begin bad++; $display("FAIL abort_height got %0d want 1", frame_height); end
        step();
        snap();
        for (int l = 0; l < 3; l++) begin drive_line(8, 2); sels[l] = sel_log; end
        total++; if (sels[0] !== 2'd0 || sels[1] !== 2'd1 || sels[2] !== 2'd2) begin bad++; $display("FAIL abort_sel got %0d,%0d,%0d want 0,1,2", sels[0], sels[1], sels[2]); end
        total++; if (cnt_valid - b_valid != 6) begin bad++; $display("FAIL abort_valid got %0d want 6", cnt_valid - b_valid); end
        total++; if (geom_err !== 1'b0) begin bad++; $display("FAIL abort_err got %b want 0", geom_err); end
    endtask

    task automatic test_overflow();
        int en_bad, addr_bad;
        frame_start();
        drive_line(21, 2);
        en_bad = 0;
        addr_bad = 0;
        for (int i = 0; i < 21; i++) if (en_log[i] !== (i < 16 ? 1'b1 : 1'b0)) en_bad++;
        for (int i = 0; i < 16; i++) if (addr_log[i] !== 4'(i) || rd_log[i] !== 4'(i)) addr_bad++;
        total++; if (en_bad != 0) begin bad++; $display("FAIL ovf_wr_en got %0d bad cycles want 0", en_bad); end
        total++; if (addr_bad != 0) begin bad++; $display("FAIL ovf_addr got %0d bad cycles want 0", addr_bad); end
        total++; if (geom_err !== 1'b1) begin bad++; $display("FAIL ovf_err got %b want 1", geom_err); end
        total++; if (frame_width !== 5'd16) begin bad++; $display("FAIL ovf_width got %0d want 16", frame_width); end
        frame_start();
        total++; if (geom_err !== 1'b0) begin bad++; $display("FAIL ovf_err_clear got %b want 0", geom_err); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_flush();
        test_geom_err();
        test_abort();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
